uart_tx: RTL and testbench

Serial transmit stage of the UART, directly downstream of the APB slave register block. It accepts bytes written through the APB data register into a small FIFO and serialises them onto the TX line as 8N1 frames (8E1 when parity is compiled in), with bit period set by the APB baud-rate register. It reports FIFO and busy status back to the APB slave for readback.

---
 rtl/uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmit stage: byte FIFO plus 8N1 serialiser.
//
// Bytes written from the APB data register are queued in a small circular
// FIFO. They are sent LSB first as start / 8 data / stop frames. The bit
// period is set by baud_div, which is latched at the start of each frame.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit. This gives 8E1 frames of 11 bit
// periods. With the macro undefined the frames are 8N1 (10 bit periods).
//
// Parameters
//   FIFO_DEPTH  TX FIFO entries (power of two, >= 2)
//   DIV_W       baud divisor width
//   CNT_W       width of tx_count
// Ports
//   P_clk       system clock, rising edge
//   P_resetn    asynchronous active-low reset
//   tx_wdata    byte to queue
//   tx_wr       one-cycle write strobe
//   baud_div    P_clk cycles per bit (0 is treated as 1)
//   tx_out      serial line, idle high, driven straight from a flop
//   tx_busy     frame in progress (any state but IDLE)
//   tx_full     FIFO holds FIFO_DEPTH entries (registered)
//   tx_empty    FIFO holds 0 entries (registered)
//   tx_count    FIFO occupancy (registered)
//   tx_ovf      one-cycle pulse after a write was dropped on a full FIFO
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             P_clk,
    input  logic             P_resetn,
    input  logic [7:0]       tx_wdata,
    input  logic             tx_wr,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_full,
    output logic             tx_empty,
    output logic [CNT_W-1:0] tx_count,
    output logic             tx_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------------------------------------------------------- FIFO
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q, ovf_q;
    logic             push, pop;

    // A pop in the same cycle never frees room for a write to a full FIFO.
    assign push = tx_wr && !full_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge P_clk) begin
        if (push) mem_q[wptr_q] <= tx_wdata;
    end

    always_ff @(posedge P_clk or negedge P_resetn) begin
        if (!P_resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == CNT_MAX);
            empty_q <= (count_d == '0);
            ovf_q   <= tx_wr && full_q;
        end
    end

    // ---------------------------------------------------------- serialiser
    state_t           state_q;
    logic [7:0]       sh_q;
    logic [2:0]       idx_q, idx_nxt;
    logic [DIV_W-1:0] per_q, cnt_q, per_new;
    logic             out_q, busy_q, bit_end;

    assign per_new = (baud_div == '0) ? DIV_ONE : baud_div;
    assign bit_end = (cnt_q == '0);
    assign idx_nxt = idx_q + 3'd1;

    // Pop from IDLE, or at the end of a stop bit so frames run back to back.
    assign pop = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    always_ff @(posedge P_clk or negedge P_resetn) begin
        if (!P_resetn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            per_q   <= DIV_ONE;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= START;
                        sh_q    <= mem_q[rptr_q];
                        per_q   <= per_new;
                        cnt_q   <= per_new - DIV_ONE;
                        out_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        cnt_q   <= per_q - DIV_ONE;
                        out_q   <= sh_q[0];
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= per_q - DIV_ONE;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            out_q   <= ^sh_q;
`else
                            state_q <= STOP;
                            out_q   <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_nxt;
                            out_q <= sh_q[idx_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        cnt_q   <= per_q - DIV_ONE;
                        out_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state_q <= START;
                            sh_q    <= mem_q[rptr_q];
                            per_q   <= per_new;
                            cnt_q   <= per_new - DIV_ONE;
                            out_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            out_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out   = out_q;
    assign tx_busy  = busy_q;
    assign tx_full  = full_q;
    assign tx_empty = empty_q;
    assign tx_count = count_q;
    assign tx_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed bench for uart_tx (default parameters).
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        P_clk = 1'b0;
    logic        P_resetn = 1'b0;
    logic [7:0]  tx_wdata = 8'h00;
    logic        tx_wr = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic        tx_out, tx_busy, tx_full, tx_empty, tx_ovf;
    logic [2:0]  tx_count;

    int errors = 0;
    int checks = 0;

    uart_tx dut (
        .P_clk    (P_clk),
        .P_resetn (P_resetn),
        .tx_wdata (tx_wdata),
        .tx_wr    (tx_wr),
        .baud_div (baud_div),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_count (tx_count),
        .tx_ovf   (tx_ovf)
    );

    always #5 P_clk = ~P_clk;

    task automatic tick();
        @(posedge P_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit b of a frame carrying d.
    function automatic logic fbit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Write one byte; returns just after the edge that samples it.
    task automatic wr(input logic [7:0] d);
        tx_wdata = d;
        tx_wr = 1'b1;
        tick();
        tx_wr = 1'b0;
    endtask

    // Called just after the pop edge; checks every cycle of the frame and
    // returns just after the edge that ends the stop bit.
    task automatic chk_frame(input string tag, input logic [7:0] d, input int per);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < per; c++) begin
                chk($sformatf("%s_b%0d_c%0d", tag, b, c), 32'(tx_out), 32'(fbit(d, b)));
                tick();
            end
        end
    endtask

    initial begin
        // ---------------------------------------------------------- reset
        tick();
        chk("rst_out",   32'(tx_out),   32'd1);
        chk("rst_busy",  32'(tx_busy),  32'd0);
        chk("rst_full",  32'(tx_full),  32'd0);
        chk("rst_empty", 32'(tx_empty), 32'd1);
        chk("rst_count", 32'(tx_count), 32'd0);
        chk("rst_ovf",   32'(tx_ovf),   32'd0);
        P_resetn = 1'b1;
        tick();
        tick();
        chk("idle_out", 32'(tx_out), 32'd1);

        // ------------------------------------------------ single byte, /4
        baud_div = 16'd4;
        wr(8'hA5);
        chk("sb_empty_after_wr", 32'(tx_empty), 32'd0);
        chk("sb_count_after_wr", 32'(tx_count), 32'd1);
        chk("sb_busy_after_wr",  32'(tx_busy),  32'd0);
        chk("sb_out_after_wr",   32'(tx_out),   32'd1);
        tick();
        chk("sb_busy_pop",  32'(tx_busy),  32'd1);
        chk("sb_empty_pop", 32'(tx_empty), 32'd1);
        chk_frame("sb", 8'hA5, 4);
        chk("sb_busy_end", 32'(tx_busy), 32'd0);
        chk("sb_out_end",  32'(tx_out),  32'd1);

        // --------------------------------------------- back-to-back, /2
        baud_div = 16'd2;
        wr(8'h00);
        wr(8'hFF);                      // same edge as the first pop
        chk("bb_count_pushpop", 32'(tx_count), 32'd1);
        chk_frame("bb0", 8'h00, 2);
        chk("bb_busy_gap",  32'(tx_busy),  32'd1);
        chk("bb_empty_2nd", 32'(tx_empty), 32'd1);
        chk_frame("bb1", 8'hFF, 2);
        chk("bb_busy_end", 32'(tx_busy), 32'd0);

        // ------------------------------------------------- divisor zero
        baud_div = 16'd0;
        wr(8'h6B);
        tick();
        chk_frame("d0", 8'h6B, 1);
        chk("d0_busy_end", 32'(tx_busy), 32'd0);

        // ------------------------------------------ divisor change 3 -> 5
        baud_div = 16'd3;
        wr(8'hC3);
        wr(8'h2D);                      // first frame popped here, period 3
        baud_div = 16'd5;
        chk_frame("dv3", 8'hC3, 3);
        chk_frame("dv5", 8'h2D, 5);
        chk("dv_busy_end", 32'(tx_busy), 32'd0);

        // ---------------------------------------------- overflow, /100
        baud_div = 16'd100;
        wr(8'h3C);
        wr(8'h81);                      // pop edge of 0x3C
        chk("ov_out_start", 32'(tx_out), 32'd0);
        wr(8'h5A);
        wr(8'h96);
        wr(8'h0F);
        chk("ov_full",       32'(tx_full),  32'd1);
        chk("ov_count4",     32'(tx_count), 32'd4);
        chk("ov_no_ovf_yet", 32'(tx_ovf),   32'd0);
        wr(8'hE7);                      // dropped
        chk("ov_pulse",      32'(tx_ovf),   32'd1);
        chk("ov_count_keep", 32'(tx_count), 32'd4);
        tick();
        chk("ov_pulse_end",  32'(tx_ovf),   32'd0);
        // Now 5 cycles into the first frame; walk to the cycle before its end.
        for (int i = 0; i < NB*100 - 6; i++) tick();
        chk("pp_stop_bit", 32'(tx_out),  32'd1);
        chk("pp_busy",     32'(tx_busy), 32'd1);
        wr(8'h77);                      // coincides with STOP->START pop
        chk("pp_ovf",   32'(tx_ovf),   32'd1);
        chk("pp_count", 32'(tx_count), 32'd3);
        chk("pp_full",  32'(tx_full),  32'd0);
        chk_frame("pp", 8'h81, 100);
        chk("pp_count2", 32'(tx_count), 32'd2);

        // ------------------------------------------------ reset mid-frame
        for (int i = 0; i < 250; i++) tick();
        chk("mf_busy_pre", 32'(tx_busy), 32'd1);
        P_resetn = 1'b0;
        #1;
        chk("mf_out",   32'(tx_out),   32'd1);
        chk("mf_busy",  32'(tx_busy),  32'd0);
        chk("mf_count", 32'(tx_count), 32'd0);
        chk("mf_empty", 32'(tx_empty), 32'd1);
        tick();
        P_resetn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("mf_line_quiet", 32'({tx_out, tx_busy}), 32'd2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
